// File: rtl/param_datapath_pkg.sv
// param_datapath_pkg: opcodes, flag bit positions and sequencer states shared by the
// parametrised datapath and its ALU.
package param_datapath_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_NOT = 4'd5;
    localparam logic [3:0] OP_SHL = 4'd6;
    localparam logic [3:0] OP_SHR = 4'd7;
    localparam logic [3:0] OP_INC = 4'd8;
    localparam logic [3:0] OP_DEC = 4'd9;
    localparam logic [3:0] OP_MOV = 4'd10;
    localparam logic [3:0] OP_CMP = 4'd11;
    localparam logic [3:0] OP_TST = 4'd12;

    localparam int FLAG_CF = 0;
    localparam int FLAG_PF = 1;
    localparam int FLAG_ZF = 2;
    localparam int FLAG_SF = 3;
    localparam int FLAG_OF = 4;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_READ = 2'd1;
    localparam logic [1:0] S_EXEC = 2'd2;
    localparam logic [1:0] S_WB   = 2'd3;

    // Opcodes 0..10 write their result back; CMP, TST and the NOP range do not.
    function automatic logic op_writes(input logic [3:0] op);
        return op <= OP_MOV;
    endfunction

    function automatic logic op_sets_flags(input logic [3:0] op);
        return op != OP_MOV && op <= OP_TST;
    endfunction

endpackage

// File: rtl/param_alu.sv
// param_alu: combinational WIDTH-bit ALU producing the result and 8086-style flags.
module param_alu
    import param_datapath_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [3:0]       opcode,
    input  logic             cf_in,
    output logic [WIDTH-1:0] res,
    output logic [7:0]       flags
);

    localparam int M = WIDTH - 1;
    localparam logic [WIDTH-1:0] ONE = 1;

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;
    logic           cf;
    logic           of;

    assign sum  = {1'b0, op_a} + {1'b0, op_b};
    assign diff = {1'b0, op_a} - {1'b0, op_b};

    always_comb begin
        res = op_a;
        cf  = 1'b0;
        of  = 1'b0;
        case (opcode)
            OP_ADD: begin
                res = sum[M:0];
                cf  = sum[WIDTH];
                of  = (op_a[M] == op_b[M]) && (res[M] != op_a[M]);
            end
            OP_SUB, OP_CMP: begin
                res = diff[M:0];
                cf  = diff[WIDTH];
                of  = (op_a[M] != op_b[M]) && (res[M] != op_a[M]);
            end
            OP_AND, OP_TST: res = op_a & op_b;
            OP_OR:  res = op_a | op_b;
            OP_XOR: res = op_a ^ op_b;
            OP_NOT: res = ~op_a;
            OP_SHL: begin
                res = {op_a[M-1:0], 1'b0};
                cf  = op_a[M];
                of  = op_a[M] ^ op_a[M-1];
            end
            OP_SHR: begin
                res = {1'b0, op_a[M:1]};
                cf  = op_a[0];
            end
            // INC/DEC keep the incoming carry, as on the 8086
            OP_INC: begin
                res = op_a + ONE;
                cf  = cf_in;
                of  = ~op_a[M] & res[M];
            end
            OP_DEC: begin
                res = op_a - ONE;
                cf  = cf_in;
                of  = op_a[M] & ~res[M];
            end
            OP_MOV: begin
                res = op_b;
                cf  = cf_in;
            end
            default: cf = cf_in;
        endcase
    end

    always_comb begin
        flags          = '0;
        flags[FLAG_CF] = cf;
        flags[FLAG_PF] = ~^res[7:0];
        flags[FLAG_ZF] = res == '0;
        flags[FLAG_SF] = res[M];
        flags[FLAG_OF] = of;
    end

endmodule

// File: rtl/param_datapath_seq.sv
// param_datapath_seq: register file plus a four-state READ/EXEC/WB sequencer around
// param_alu, driven by a start/busy/done handshake.
module param_datapath_seq
    import param_datapath_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NREGS = 8,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load_en,
    input  logic [AW-1:0]    load_addr,
    input  logic [WIDTH-1:0] load_data,
    input  logic             start,
    output logic             ready,
    input  logic [3:0]       opcode,
    input  logic [AW-1:0]    src_a,
    input  logic [AW-1:0]    src_b,
    input  logic [AW-1:0]    dst,
    input  logic             use_imm,
    input  logic [WIDTH-1:0] imm,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [7:0]       flags,
    input  logic [AW-1:0]    dbg_addr,
    output logic [WIDTH-1:0] dbg_data
);

    logic [1:0]       state;
    logic [3:0]       op_q;
    logic [AW-1:0]    src_a_q;
    logic [AW-1:0]    src_b_q;
    logic [AW-1:0]    dst_q;
    logic             use_imm_q;
    logic [WIDTH-1:0] imm_q;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] alu_res_q;
    logic [7:0]       alu_flags;
    logic [7:0]       alu_flags_q;
    logic [WIDTH-1:0] regs [NREGS];

    assign ready    = state == S_IDLE && !load_en;
    assign busy     = state != S_IDLE;
    assign done     = state == S_WB;
    assign dbg_data = regs[dbg_addr];

    param_alu #(.WIDTH(WIDTH)) u_alu (
        .op_a   (op_a),
        .op_b   (op_b),
        .opcode (op_q),
        .cf_in  (flags[FLAG_CF]),
        .res    (alu_res),
        .flags  (alu_flags)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            op_q        <= '0;
            src_a_q     <= '0;
            src_b_q     <= '0;
            dst_q       <= '0;
            use_imm_q   <= 1'b0;
            imm_q       <= '0;
            op_a        <= '0;
            op_b        <= '0;
            alu_res_q   <= '0;
            alu_flags_q <= '0;
            result      <= '0;
            flags       <= '0;
        end else begin
            case (state)
                S_IDLE: if (start && ready) begin
                    op_q      <= opcode;
                    src_a_q   <= src_a;
                    src_b_q   <= src_b;
                    dst_q     <= dst;
                    use_imm_q <= use_imm;
                    imm_q     <= imm;
                    state     <= S_READ;
                end
                // operands are captured here, so a dst that aliases a source is safe
                S_READ: begin
                    op_a  <= regs[src_a_q];
                    op_b  <= use_imm_q ? imm_q : regs[src_b_q];
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    alu_res_q   <= alu_res;
                    alu_flags_q <= alu_flags;
                    state       <= S_WB;
                end
                default: begin
                    result <= alu_res_q;
                    if (op_sets_flags(op_q))
                        flags <= alu_flags_q;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++)
                regs[i] <= '0;
        end else if (state == S_IDLE && load_en) begin
            regs[load_addr] <= load_data;
        end else if (state == S_WB && op_writes(op_q)) begin
            regs[dst_q] <= alu_res_q;
        end
    end

endmodule

// File: tb/tb_param_datapath_seq.sv
// tb_param_datapath_seq: directed scenarios for the 8-bit datapath plus one 16-bit carry case.
module tb_param_datapath_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       load_en;
    logic [2:0] load_addr;
    logic [7:0] load_data;
    logic       start;
    logic       ready;
    logic [3:0] opcode;
    logic [2:0] src_a;
    logic [2:0] src_b;
    logic [2:0] dst;
    logic       use_imm;
    logic [7:0] imm;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic [7:0] flags;
    logic [2:0] dbg_addr;
    logic [7:0] dbg_data;

    logic        load_en16;
    logic [2:0]  load_addr16;
    logic [15:0] load_data16;
    logic        start16;
    logic        ready16;
    logic [3:0]  opcode16;
    logic [2:0]  src_a16;
    logic [2:0]  src_b16;
    logic [2:0]  dst16;
    logic        use_imm16;
    logic [15:0] imm16;
    logic        busy16;
    logic        done16;
    logic [15:0] result16;
    logic [7:0]  flags16;
    logic [2:0]  dbg_addr16;
    logic [15:0] dbg_data16;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    param_datapath_seq #(.WIDTH(8), .NREGS(8)) dut (
        .clock(clk), .reset(rst_n), .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data), .start(start), .ready(ready), .opcode(opcode),
        .src_a(src_a), .src_b(src_b), .dst(dst), .use_imm(use_imm), .imm(imm),
        .busy(busy), .done(done), .result(result), .flags(flags),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    param_datapath_seq #(.WIDTH(16), .NREGS(8)) dut16 (
        .clock(clk), .reset(rst_n), .load_en(load_en16), .load_addr(load_addr16),
        .load_data(load_data16), .start(start16), .ready(ready16), .opcode(opcode16),
        .src_a(src_a16), .src_b(src_b16), .dst(dst16), .use_imm(use_imm16), .imm(imm16),
        .busy(busy16), .done(done16), .result(result16), .flags(flags16),
        .dbg_addr(dbg_addr16), .dbg_data(dbg_data16)
    );

    // {opcode, a, b, expected R7 afterwards, expected flags, writes}, applied in order
    localparam logic [36:0] VEC [11] = '{
        {4'd2,  8'hF0, 8'h3C, 8'h30, 8'h02, 1'b1},
        {4'd3,  8'hF0, 8'h0F, 8'hFF, 8'h0A, 1'b1},
        {4'd4,  8'hAA, 8'hAA, 8'h00, 8'h06, 1'b1},
        {4'd5,  8'h55, 8'h00, 8'hAA, 8'h0A, 1'b1},
        {4'd6,  8'hC1, 8'h00, 8'h82, 8'h0B, 1'b1},
        {4'd7,  8'h03, 8'h00, 8'h01, 8'h01, 1'b1},
        {4'd9,  8'h80, 8'h00, 8'h7F, 8'h11, 1'b1},
        {4'd10, 8'h00, 8'h5A, 8'h5A, 8'h11, 1'b1},
        {4'd13, 8'h00, 8'h00, 8'h5A, 8'h11, 1'b0},
        {4'd1,  8'h80, 8'h01, 8'h7F, 8'h10, 1'b1},
        {4'd12, 8'h0F, 8'hF0, 8'h7F, 8'h06, 1'b0}
    };

    task automatic load(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        load_en = 1'b1; load_addr = a; load_data = d;
        @(posedge clk); #1;
        load_en = 1'b0;
    endtask

    task automatic issue(input logic [3:0] op, input logic [2:0] a, input logic [2:0] b,
                         input logic [2:0] d, input logic ui, input logic [7:0] im);
        @(negedge clk);
        start = 1'b1; opcode = op; src_a = a; src_b = b; dst = d; use_imm = ui; imm = im;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // issue, then record done after each of the next three edges: {T+3, T+2, T+1}
    task automatic run(input logic [3:0] op, input logic [2:0] a, input logic [2:0] b,
                       input logic [2:0] d, input logic ui, input logic [7:0] im,
                       output logic [2:0] seq);
        issue(op, a, b, d, ui, im);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            seq[k] = done;
        end
    endtask

    task automatic peek(input logic [2:0] a, output logic [7:0] d);
        dbg_addr = a;
        #1;
        d = dbg_data;
    endtask

    task automatic test_reset;
        logic [7:0] v;
        checks++; if ({busy, done, ready} !== 3'b001) begin errors++; $display("FAIL reset_hs got=%b exp=001", {busy, done, ready}); end
        checks++; if ({result, flags} !== 16'h0000) begin errors++; $display("FAIL reset_out got=%h exp=0000", {result, flags}); end
        for (int r = 0; r < 8; r += 5) begin
            peek(r[2:0], v);
            checks++; if (v !== 8'h00) begin errors++; $display("FAIL reset_reg%0d got=%h exp=00", r, v); end
        end
    endtask

    task automatic test_add;
        logic [2:0] seq;
        logic [7:0] v;
        load(3'd0, 8'h7F);
        load(3'd1, 8'h01);
        run(4'd0, 3'd0, 3'd1, 3'd2, 1'b0, 8'h00, seq);
        peek(3'd2, v);
        checks++; if (seq !== 3'b010) begin errors++; $display("FAIL add_done got=%b exp=010", seq); end
        checks++; if (v !== 8'h80) begin errors++; $display("FAIL add_r2 got=%h exp=80", v); end
        checks++; if (result !== 8'h80) begin errors++; $display("FAIL add_result got=%h exp=80", result); end
        checks++; if (flags !== 8'h18) begin errors++; $display("FAIL add_flags got=%h exp=18", flags); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL add_busy got=%b exp=0", busy); end
    endtask

    task automatic test_sub_cmp;
        logic [2:0] seq;
        logic [7:0] v;
        load(3'd3, 8'h00);
        run(4'd1, 3'd3, 3'd0, 3'd4, 1'b1, 8'h01, seq);
        peek(3'd4, v);
        checks++; if (v !== 8'hFF) begin errors++; $display("FAIL sub_r4 got=%h exp=ff", v); end
        checks++; if (flags !== 8'h0B) begin errors++; $display("FAIL sub_flags got=%h exp=0b", flags); end
        run(4'd11, 3'd4, 3'd0, 3'd4, 1'b1, 8'hFF, seq);
        peek(3'd4, v);
        checks++; if (seq !== 3'b010) begin errors++; $display("FAIL cmp_done got=%b exp=010", seq); end
        checks++; if (flags !== 8'h06) begin errors++; $display("FAIL cmp_flags got=%h exp=06", flags); end
        checks++; if (v !== 8'hFF) begin errors++; $display("FAIL cmp_r4 got=%h exp=ff", v); end
        checks++; if (result !== 8'h00) begin errors++; $display("FAIL cmp_result got=%h exp=00", result); end
    endtask

    task automatic test_inc_carry;
        logic [2:0] seq;
        logic [7:0] v;
        run(4'd1, 3'd3, 3'd0, 3'd6, 1'b1, 8'h01, seq);
        checks++; if (flags !== 8'h0B) begin errors++; $display("FAIL inc_pre_flags got=%h exp=0b", flags); end
        load(3'd5, 8'hFF);
        run(4'd8, 3'd5, 3'd0, 3'd5, 1'b0, 8'h00, seq);
        peek(3'd5, v);
        checks++; if (v !== 8'h00) begin errors++; $display("FAIL inc_r5 got=%h exp=00", v); end
        checks++; if (flags !== 8'h07) begin errors++; $display("FAIL inc_flags got=%h exp=07", flags); end
    endtask

    task automatic test_alu_table;
        logic [2:0] seq;
        logic [7:0] v;
        for (int i = 0; i < 11; i++) begin
            load(3'd0, VEC[i][32:25]);
            load(3'd1, VEC[i][24:17]);
            run(VEC[i][36:33], 3'd0, 3'd1, 3'd7, 1'b0, 8'h00, seq);
            peek(3'd7, v);
            checks++; if (seq !== 3'b010) begin errors++; $display("FAIL vec%0d_done got=%b exp=010", i, seq); end
            checks++; if (v !== VEC[i][16:9]) begin errors++; $display("FAIL vec%0d_r7 got=%h exp=%h", i, v, VEC[i][16:9]); end
            checks++; if (flags !== VEC[i][8:1]) begin errors++; $display("FAIL vec%0d_flags got=%h exp=%h", i, flags, VEC[i][8:1]); end
            if (VEC[i][0]) begin
                checks++; if (result !== VEC[i][16:9]) begin errors++; $display("FAIL vec%0d_result got=%h exp=%h", i, result, VEC[i][16:9]); end
            end
        end
    endtask

    task automatic test_width16;
        logic [2:0] seq;
        @(negedge clk);
        load_en16 = 1'b1; load_addr16 = 3'd0; load_data16 = 16'hFFFF;
        @(negedge clk);
        load_addr16 = 3'd1; load_data16 = 16'h0001;
        @(negedge clk);
        load_en16 = 1'b0;
        start16 = 1'b1; opcode16 = 4'd0; src_a16 = 3'd0; src_b16 = 3'd1; dst16 = 3'd2;
        @(posedge clk); #1;
        start16 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            seq[k] = done16;
        end
        dbg_addr16 = 3'd2;
        #1;
        checks++; if (seq !== 3'b010) begin errors++; $display("FAIL w16_done got=%b exp=010", seq); end
        checks++; if (dbg_data16 !== 16'h0000) begin errors++; $display("FAIL w16_r2 got=%h exp=0000", dbg_data16); end
        checks++; if (flags16 !== 8'h07) begin errors++; $display("FAIL w16_flags got=%h exp=07", flags16); end
    endtask

    task automatic test_ignored_start;
        logic [7:0] v;
        int dones = 0;
        load(3'd6, 8'h44);
        issue(4'd0, 3'd0, 3'd1, 3'd2, 1'b0, 8'h00);
        @(negedge clk);
        start = 1'b1; opcode = 4'd10; src_b = 3'd0; dst = 3'd6;
        @(posedge clk); #1;
        @(posedge clk); #1;
        dones += int'(done);
        start = 1'b0;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_start_queued got=%b exp=0", busy); end
        @(negedge clk);
        load_en = 1'b1; load_addr = 3'd6; load_data = 8'h33;
        start = 1'b1; opcode = 4'd0; src_a = 3'd0; src_b = 3'd1; dst = 3'd5;
        #1;
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL load_ready got=%b exp=0", ready); end
        @(posedge clk); #1;
        load_en = 1'b0; start = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL load_start_taken got=%b exp=0", busy); end
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            dones += int'(done);
        end
        checks++; if (dones !== 1) begin errors++; $display("FAIL stray_done got=%0d exp=1", dones); end
        peek(3'd6, v);
        checks++; if (v !== 8'h33) begin errors++; $display("FAIL load_r6 got=%h exp=33", v); end
    endtask

    task automatic test_reset_abort;
        logic [7:0] v;
        int dones = 0;
        load(3'd0, 8'h11);
        load(3'd1, 8'h22);
        issue(4'd0, 3'd0, 3'd1, 3'd2, 1'b0, 8'h00);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL abort_hs got=%b exp=00", {busy, done}); end
        peek(3'd0, v);
        checks++; if (v !== 8'h00) begin errors++; $display("FAIL abort_r0 got=%h exp=00", v); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            dones += int'(done);
        end
        peek(3'd2, v);
        checks++; if (v !== 8'h00 || dones !== 0) begin errors++; $display("FAIL abort_wb got=%h/%0d exp=00/0", v, dones); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] seq;
        logic [7:0] v;
        seq = '0;
        load(3'd0, 8'h05);
        load(3'd1, 8'h03);
        issue(4'd0, 3'd0, 3'd1, 3'd0, 1'b0, 8'h00);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (k == 4) begin
                start = 1'b1; opcode = 4'd0; src_a = 3'd0; src_b = 3'd1; dst = 3'd3;
            end
            @(posedge clk); #1;
            start = 1'b0;
            seq[k] = done;
        end
        checks++; if (seq !== 8'b0100_0100) begin errors++; $display("FAIL b2b_done got=%b exp=01000100", seq); end
        peek(3'd0, v);
        checks++; if (v !== 8'h08) begin errors++; $display("FAIL b2b_r0 got=%h exp=08", v); end
        peek(3'd3, v);
        checks++; if (v !== 8'h0B) begin errors++; $display("FAIL b2b_r3 got=%h exp=0b", v); end
    endtask

    initial begin
        rst_n = 1'b0;
        load_en = 1'b0; load_addr = '0; load_data = '0;
        start = 1'b0; opcode = '0; src_a = '0; src_b = '0; dst = '0;
        use_imm = 1'b0; imm = '0; dbg_addr = '0;
        load_en16 = 1'b0; load_addr16 = '0; load_data16 = '0;
        start16 = 1'b0; opcode16 = '0; src_a16 = '0; src_b16 = '0; dst16 = '0;
        use_imm16 = 1'b0; imm16 = '0; dbg_addr16 = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_add();
        test_sub_cmp();
        test_inc_carry();
        test_alu_table();
        test_width16();
        test_ignored_start();
        test_reset_abort();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
